mem_access_unit: RTL and testbench

- Parametrised memory access unit between the multicycle control unit and RAM; successor to the fixed MAR/MDR plus MOC arrangement.
- Latches an access request and drives a word-addressed memory port with byte enables, then completes with a one-cycle MOC pulse.
- Supports byte, halfword and word loads/stores, with sign or zero extension on loads and misalignment detection.
- Memory latency is variable; the block waits on an ack handshake, with an optional timeout.

---
 rtl/mau_pkg.sv | 19 +
 rtl/mau_lane_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states, timeout counter width.
package mau_pkg;

    localparam int unsigned MAU_CNT_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mau_size_e;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_DONE   = 2'd2
    } mau_state_e;

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: byte enables, store replication, load extract/extend, misalign detect.
module mau_lane_align
    import mau_pkg::*;
#(
    parameter int unsigned BIG_END = 1
) (
    input  logic [1:0]  size,
    input  logic        unsign,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c,
    output logic        misalign_c
);

    logic [3:0]  mask;
    logic [1:0]  lane;
    logic [31:0] shifted;

    // lane = index of the least significant byte lane touched by the access
    always_comb begin
        mask       = 4'b0000;
        lane       = 2'd0;
        misalign_c = 1'b0;
        wdata_c    = wdata;
        case (size)
            SZ_BYTE: begin
                mask    = 4'b0001;
                lane    = (BIG_END != 0) ? (2'd3 - off) : off;
                wdata_c = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                mask       = 4'b0011;
                lane       = (BIG_END != 0) ? (2'd2 - off) : off;
                wdata_c    = {2{wdata[15:0]}};
                misalign_c = off[0];
            end
            SZ_WORD: begin
                mask       = 4'b1111;
                misalign_c = (off != 2'd0);
            end
            default: misalign_c = 1'b1;
        endcase
    end

    assign be_c    = mask << lane;
    assign shifted = mem_rdata >> {lane, 3'b000};

    always_comb begin
        rdata_c = 32'd0;
        case (size)
            SZ_BYTE: rdata_c = {{24{~unsign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_c = {{16{~unsign & shifted[15]}}, shifted[15:0]};
            SZ_WORD: rdata_c = shifted;
            default: rdata_c = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: latches a CPU access, drives a word-addressed RAM port, ends with a MOC pulse.
// Optional ACCESS timeout enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned BIG_END  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              unsign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              moc,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    mau_state_e        state_q, state_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic              unsign_q, unsign_d;
    logic [1:0]        off_q, off_d;
    logic              busy_q, busy_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

`ifdef MAU_TIMEOUT_EN
    localparam logic [MAU_CNT_W-1:0] CNT_LAST = MAU_CNT_W'(WAIT_MAX - 1);
    logic [MAU_CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_wait_max;
    assign unused_wait_max = ^MAU_CNT_W'(WAIT_MAX);
`endif

    // Aligner sees live inputs while IDLE (decode) and the latched request afterwards (load extract)
    logic        idle_c;
    logic [1:0]  al_size_c;
    logic        al_unsign_c;
    logic [1:0]  al_off_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] rd_ext_c;
    logic        misalign_c;

    assign idle_c      = (state_q == MAU_IDLE);
    assign al_size_c   = idle_c ? size   : size_q;
    assign al_unsign_c = idle_c ? unsign : unsign_q;
    assign al_off_c    = idle_c ? addr[1:0] : off_q;

    mau_lane_align #(
        .BIG_END (BIG_END)
    ) u_align (
        .size       (al_size_c),
        .unsign     (al_unsign_c),
        .off        (al_off_c),
        .wdata      (wdata),
        .mem_rdata  (mem_rdata),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .rdata_c    (rd_ext_c),
        .misalign_c (misalign_c)
    );

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        size_d      = size_q;
        unsign_d    = unsign_q;
        off_d       = off_q;
        busy_d      = 1'b0;
        moc_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MAU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            MAU_IDLE: begin
                if (req) begin
                    rw_d     = rw;
                    size_d   = size;
                    unsign_d = unsign;
                    off_d    = addr[1:0];
                    busy_d   = 1'b1;
                    if (misalign_c) begin
                        state_d = MAU_DONE;
                        moc_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = MAU_ACCESS;
                        mem_en_d    = 1'b1;
                        mem_rw_d    = rw;
                        mem_addr_d  = addr[ADDR_W-1:2];
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
`ifdef MAU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            MAU_ACCESS: begin
                busy_d = 1'b1;
                if (mem_ack) begin
                    state_d = MAU_DONE;
                    moc_d   = 1'b1;
                    if (rw_q) begin
                        rdata_d = rd_ext_c;
                    end
`ifdef MAU_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d = MAU_DONE;
                    moc_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    mem_en_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
`else
                end else begin
                    mem_en_d = 1'b1;
                end
`endif
            end
            MAU_DONE: begin
                state_d = MAU_IDLE;
            end
            default: begin
                state_d = MAU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MAU_IDLE;
            rw_q        <= 1'b0;
            size_q      <= 2'd0;
            unsign_q    <= 1'b0;
            off_q       <= 2'd0;
            busy_q      <= 1'b0;
            moc_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
`ifdef MAU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            unsign_q    <= unsign_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            moc_q       <= moc_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MAU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign moc       = moc_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random accesses against a byte-level memory model.
module tb_mem_access_unit;

    localparam int BIG_END_T = 1;

    logic        clk;
    logic        reset;
    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic        unsign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        moc;
    logic        err;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_rw;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          total;
    int          bad;
    logic [31:0] exp_rdata;

    mem_access_unit #(
        .ADDR_W   (32),
        .WAIT_MAX (4),
        .BIG_END  (BIG_END_T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rw        (rw),
        .size      (size),
        .unsign    (unsign),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .moc       (moc),
        .err       (err),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory seen as four bytes in address order; lane_of maps address offset to byte lane
    function automatic int lane_of(input int i);
        return (BIG_END_T != 0) ? (3 - i) : i;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int o;
        be = 4'b0000;
        o  = int'(a[1:0]);
        for (int k = 0; k < nbytes(sz); k++) be[lane_of(o + k)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return {4{wd[7:0]}};
        if (sz == 2'b01) return {2{wd[15:0]}};
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u,
                                               input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        logic [7:0]  b;
        int o;
        int n;
        v = 32'd0;
        o = int'(a[1:0]);
        n = nbytes(sz);
        for (int k = 0; k < n; k++) begin
            b = w[8*lane_of(o + k) +: 8];
            if (BIG_END_T != 0) v = (v << 8) | 32'(b);
            else                v = v | (32'(b) << (8*k));
        end
        if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // One complete access: request for one cycle, ack after dly wait cycles
    task automatic do_access(input logic r, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd_word, input int dly);
        logic mis;
        mis       = model_mis(sz, a);
        req       = 1'b1;
        rw        = r;
        size      = sz;
        unsign    = u;
        addr      = a;
        wdata     = wd;
        mem_rdata = $urandom;
        mem_ack   = 1'($urandom_range(0, 1));
        step();
        req       = 1'b0;
        mem_ack   = 1'b0;
        rw        = 1'($urandom);
        size      = 2'($urandom);
        unsign    = 1'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        if (mis) begin
            check_b("mis_mem_en", mem_en, 1'b0);
            check_b("mis_moc", moc, 1'b1);
            check_b("mis_err", err, 1'b1);
            check_b("mis_busy", busy, 1'b1);
            check("mis_rdata", rdata, exp_rdata);
            step();
            check_b("mis_moc_end", moc, 1'b0);
            check_b("mis_busy_end", busy, 1'b0);
            check_b("mis_mem_en_end", mem_en, 1'b0);
        end else begin
            check_b("acc_mem_en", mem_en, 1'b1);
            check_b("acc_busy", busy, 1'b1);
            check_b("acc_moc", moc, 1'b0);
            check("acc_mem_addr", 32'(mem_addr), {2'b00, a[31:2]});
            check("acc_mem_be", 32'(mem_be), 32'(model_be(sz, a)));
            check_b("acc_mem_rw", mem_rw, r);
            if (!r) check("acc_mem_wdata", mem_wdata, model_wdata(sz, wd));
            for (int i = 0; i < dly; i++) begin
                step();
                check_b("wait_mem_en", mem_en, 1'b1);
                check_b("wait_moc", moc, 1'b0);
            end
            mem_ack   = 1'b1;
            mem_rdata = rd_word;
            step();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (r) exp_rdata = model_load(sz, u, a, rd_word);
            check_b("done_moc", moc, 1'b1);
            check_b("done_err", err, 1'b0);
            check_b("done_busy", busy, 1'b1);
            check_b("done_mem_en", mem_en, 1'b0);
            check("done_rdata", rdata, exp_rdata);
            step();
            check_b("idle_moc", moc, 1'b0);
            check_b("idle_busy", busy, 1'b0);
            check("idle_rdata", rdata, exp_rdata);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_rdata = 32'd0;
        reset     = 1'b1;
        req       = 1'b0;
        rw        = 1'b0;
        size      = 2'b00;
        unsign    = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;
        step();
        step();
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_moc", moc, 1'b0);
        check_b("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check_b("rst_mem_en", mem_en, 1'b0);
        check_b("rst_mem_rw", mem_rw, 1'b0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        step();

        // Directed cases
        do_access(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 3);
        check("word_load_const", rdata, 32'hDEAD_BEEF);
        do_access(1'b1, 2'b00, 1'b0, 32'h3, 32'd0, 32'h8012_3456, 1);
        check("byte3_const", rdata, 32'h0000_0056);
        do_access(1'b1, 2'b00, 1'b0, 32'h0, 32'd0, 32'h8012_3456, 0);
        check("byte0_sext_const", rdata, 32'hFFFF_FF80);
        do_access(1'b1, 2'b00, 1'b1, 32'h0, 32'd0, 32'h8012_3456, 2);
        check("byte0_zext_const", rdata, 32'h0000_0080);
        do_access(1'b0, 2'b01, 1'b0, 32'h2, 32'h0000_ABCD, 32'h1111_2222, 2);
        check("half_store_rdata_kept", rdata, 32'h0000_0080);
        do_access(1'b1, 2'b10, 1'b0, 32'h6, 32'd0, 32'h0, 0);
        do_access(1'b1, 2'b11, 1'b0, 32'h8, 32'd0, 32'h0, 0);
        do_access(1'b1, 2'b01, 1'b0, 32'h1, 32'd0, 32'h0, 0);
`ifndef MAU_TIMEOUT_EN
        do_access(1'b1, 2'b01, 1'b0, 32'h1002, 32'd0, 32'h1234_F00D, 20);
`endif

        // Reset in the middle of an access
        req    = 1'b1;
        rw     = 1'b1;
        size   = 2'b10;
        addr   = 32'h20;
        step();
        req    = 1'b0;
        check_b("pre_rst_mem_en", mem_en, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rdata = 32'd0;
        check_b("abort_mem_en", mem_en, 1'b0);
        check_b("abort_moc", moc, 1'b0);
        check_b("abort_busy", busy, 1'b0);
        check("abort_rdata", rdata, 32'd0);

        // Request held high through the whole busy window
        req  = 1'b1;
        rw   = 1'b1;
        size = 2'b10;
        addr = 32'h40;
        step();
        check_b("hold_mem_en1", mem_en, 1'b1);
        check_b("hold_busy1", busy, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        step();
        mem_ack   = 1'b0;
        exp_rdata = 32'hCAFE_0001;
        check_b("hold_moc1", moc, 1'b1);
        check("hold_rdata1", rdata, exp_rdata);
        step();
        check_b("hold_after_moc_en", mem_en, 1'b0);
        check_b("hold_after_moc_busy", busy, 1'b0);
        check_b("hold_after_moc_moc", moc, 1'b0);
        step();
        req = 1'b0;
        check_b("hold_mem_en2", mem_en, 1'b1);
        check_b("hold_busy2", busy, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_0002;
        step();
        mem_ack   = 1'b0;
        exp_rdata = 32'hCAFE_0002;
        check_b("hold_moc2", moc, 1'b1);
        check("hold_rdata2", rdata, exp_rdata);
        step();
        check_b("hold_idle_busy", busy, 1'b0);

`ifdef MAU_TIMEOUT_EN
        // No ack: mem_en for exactly WAIT_MAX cycles, then an errored completion
        req  = 1'b1;
        rw   = 1'b1;
        size = 2'b10;
        addr = 32'h100;
        step();
        req  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_b("to_mem_en", mem_en, 1'b1);
            check_b("to_moc", moc, 1'b0);
            if (i < 3) step();
        end
        step();
        check_b("to_done_moc", moc, 1'b1);
        check_b("to_done_err", err, 1'b1);
        check_b("to_done_mem_en", mem_en, 1'b0);
        check("to_done_rdata", rdata, exp_rdata);
        step();
        check_b("to_idle_moc", moc, 1'b0);
        check_b("to_idle_busy", busy, 1'b0);
        do_access(1'b1, 2'b10, 1'b0, 32'h104, 32'd0, 32'h5A5A_A5A5, 3);
`endif

        // Random accesses
        for (int n = 0; n < 60; n++) begin
            logic        r_r;
            logic [1:0]  r_sz;
            logic        r_u;
            logic [31:0] r_a;
            r_r  = 1'($urandom);
            r_sz = 2'($urandom);
            r_u  = 1'($urandom);
            r_a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                r_a[1:0] = (r_sz == 2'b10) ? 2'b00 :
                           (r_sz == 2'b01) ? {r_a[1], 1'b0} : r_a[1:0];
            end
            do_access(r_r, r_sz, r_u, r_a, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
